// File: rtl/fir_word_serializer.sv
// fir_word_serializer: buffers FIR output words in a small FIFO and shifts each out LSB-first on a 1-bit link.
// Latency: word pushed into an empty idle block at edge k loads at edge k+1; bit 0 is valid in the cycle after.
// Backpressure: o_word_ready drops when the FIFO is full; i_ready=0 holds the pending serial bit stable.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_en                     global enable; 0 freezes every register and masks o_dout_valid
//   i_word/_valid, o_word_ready   parallel input handshake
//   o_dout/_valid, i_ready        serial output handshake, one bit per transfer
//   o_fifo_count             words queued (excludes the word in the shifter)
//   o_busy                   shifter holds a word that is not fully sent
//
// Optional: define SERIALIZER_PARITY_EN to append an even-parity bit after bit DATA_WIDTH-1.
module fir_word_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_en,
  input  logic [DATA_WIDTH-1:0]              i_word,
  input  logic                               i_word_valid,
  output logic                               o_word_ready,
  input  logic                               i_ready,
  output logic                               o_dout,
  output logic                               o_dout_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
  output logic                               o_busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_W = DATA_WIDTH + 1;
`else
  localparam int FRAME_W = DATA_WIDTH;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;

  logic                  push, pop, xfer, last_bit, fifo_empty;
  logic [FRAME_W-1:0]    load_frame;

  assign fifo_empty   = (count_q == '0);
  assign o_word_ready = !i_rst && i_en && (count_q < DEPTH_C);
  assign o_dout_valid = i_en && (state_q == ST_SHIFT);
  assign o_dout       = shift_q[0];
  assign o_busy       = (state_q == ST_SHIFT);
  assign o_fifo_count = count_q;

  // All state changes are qualified by i_en through these three strobes.
  assign push     = i_word_valid && o_word_ready;
  assign xfer     = o_dout_valid && i_ready;
  assign last_bit = (bit_cnt_q == LAST_BIT);
  // Pop uses the pre-push count, so a word pushed into an empty FIFO loads one edge later.
  assign pop      = i_en && !fifo_empty && ((state_q == ST_IDLE) || (xfer && last_bit));

`ifdef SERIALIZER_PARITY_EN
  // Parity sits above the data so it reaches bit 0 after DATA_WIDTH shifts.
  assign load_frame = {^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
`else
  assign load_frame = mem_q[rd_ptr_q];
`endif

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;

    if (push) begin
      mem_d[wr_ptr_q] = i_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      // Covers both the IDLE load and the zero-gap reload after the last bit.
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      shift_d   = load_frame;
      bit_cnt_d = '0;
      state_d   = ST_SHIFT;
    end else if (xfer) begin
      shift_d = shift_q >> 1;
      if (last_bit) begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: doc/fir_word_serializer.md
Name: fir_word_serializer

Overview:
- Parallel-to-serial output stage directly downstream of the FIR core inside top_level.
- Accepts DATA_WIDTH-bit filtered samples through a valid/ready handshake.
- Buffers them in a small FIFO and shifts each word out LSB-first on a one-bit serial link with its own valid/ready handshake.
- Mirrors the serial framing the input deserializer expects: one bit per transfer cycle, no framing bits unless the optional parity is enabled.

Parameters:
- DATA_WIDTH, 24, width of each parallel sample word.
- FIFO_DEPTH, 4, number of word entries in the input FIFO; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  global enable; 0 freezes all state.
- i_word  in  DATA_WIDTH  parallel sample from the FIR core.
- i_word_valid  in  1  i_word is valid this cycle.
- o_word_ready  out  1  block can accept i_word this cycle.
- i_ready  in  1  downstream serial sink can accept a bit.
- o_dout  out  1  serial data bit.
- o_dout_valid  out  1  o_dout is valid this cycle.
- o_fifo_count  out  $clog2(FIFO_DEPTH+1)  words held in the FIFO; excludes the word in the shifter.
- o_busy  out  1  shifter holds a word not yet fully sent.

Behaviour:
- Reset (i_rst=1 at an edge):
  - FIFO emptied, pointers 0, FSM to IDLE, bit counter 0, shift register 0.
  - o_dout=0, o_dout_valid=0, o_busy=0, o_fifo_count=0.
  - o_word_ready=0 while i_rst is high.
  - Reset mid-word discards the word being shifted and all queued words. The first serial bit after reset is bit 0 of the next word pushed.
- o_word_ready = !i_rst && i_en && (o_fifo_count < FIFO_DEPTH). Combinational; does not depend on i_word_valid.
- Push: occurs at an edge where i_word_valid && o_word_ready. The word is written at the write pointer, which increments modulo FIFO_DEPTH. When full, o_word_ready=0 and i_word is ignored; there is no overwrite.
- Bit transfer: occurs at an edge where o_dout_valid && i_ready && i_en.
- i_en=0:
  - No push, pop, shift or counter change.
  - o_dout_valid forced to 0.
  - On re-enable, resumes with the same pending bit and the same value.
- FSM states:
  - IDLE:
    - o_dout_valid=0.
    - If FIFO is non-empty and i_en=1: pop the head into the shift register, bit counter=0, go to SHIFT.
  - SHIFT:
    - o_dout_valid=1, o_dout=shift_reg[0], o_busy=1.
    - On a bit transfer that is not the last bit: shift right by 1 and increment the counter.
    - On transfer of the last bit (counter=DATA_WIDTH-1): if the FIFO is non-empty, pop and load the next word in the same edge and stay in SHIFT with counter=0, giving zero-gap back-to-back words. Otherwise go to IDLE.
    - i_ready=0 holds o_dout and o_dout_valid stable. Once asserted, valid is never dropped without a transfer, except via i_en=0 or reset.
- Simultaneous push and pop in the same edge: the count is unchanged and both pointers advance. This is legal at any occupancy where o_word_ready=1. When full, a push cannot coincide with a pop, because ready was 0 during that cycle.
- Latency: with an empty FIFO and IDLE, a word pushed at edge k is popped at edge k+1. Bit 0 is valid during the cycle after edge k+1.
- Throughput: one word per DATA_WIDTH cycles at i_ready=1 (DATA_WIDTH+1 with parity).
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. The count is tracked separately, so full and empty are unambiguous.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After bit DATA_WIDTH-1, SHIFT emits one extra bit with o_dout_valid=1: the even-parity bit (XOR of all DATA_WIDTH data bits), computed at load time.
  - The frame is DATA_WIDTH+1 transfers; the last-bit condition becomes counter=DATA_WIDTH.
  - Back-to-back loading happens after the parity transfer.
- Undefined: no parity logic is instantiated; the frame is exactly DATA_WIDTH bits.

Test Plan:
- Reset, then push 24'hA5C3F0 with i_ready=1 -> o_dout_valid rises 2 edges after the push. The 24 consecutive bits LSB-first are 0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. Then o_dout_valid=0 and o_busy=0.
- Push 24'h000001 and 24'hFFFFFE on consecutive cycles, i_ready=1 -> 48 contiguous valid cycles with no gap. Bit 0 of the second word directly follows bit 23 of the first.
- Push 24'h123456 while toggling i_ready 1,0,1,0... -> the reassembled word equals 24'h123456. o_dout stays stable on every i_ready=0 cycle. Total of 48 valid cycles.
- Hold i_ready=0 and offer 6 words -> first popped into the shifter, next 4 fill the FIFO. o_fifo_count=4, o_word_ready=0, 6th word is refused. Release i_ready -> all 5 accepted words emerge in order.
- Assert i_rst for 1 cycle at bit 10 of a word, with 2 words queued -> o_dout_valid=0 and o_fifo_count=0 next cycle. A subsequent push of 24'h00ABCD serializes correctly from bit 0.
- With SERIALIZER_PARITY_EN defined, push 24'h000007 -> 25 transfers; the last bit is 1 (odd ones count). With 24'h000003 the last bit is 0.
